seq_gen: RTL and testbench

SEQ_GEN -- requirements
Module: seq_gen

---
 rtl/seq_gen.sv | 183 ++++++++++++++++++
 tb/tb_seq_gen.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
// Burst nibble transmitter: emits count nibbles from a 16-entry pattern with GAP idle cycles between load strobes.
// Define SEQ_GEN_PROG_EN to make the pattern a writable register file with wr_en/wr_addr/wr_data ports.
module seq_gen #(
   parameter int unsigned GAP = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [3:0] first,
   input  logic [4:0] count,
`ifdef SEQ_GEN_PROG_EN
   input  logic       wr_en,
   input  logic [3:0] wr_addr,
   input  logic [3:0] wr_data,
`endif
   output logic [3:0] data,
   output logic       load,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EMIT,
      ST_GAP,
      ST_DONE
   } state_t;

   localparam logic [3:0] GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

   function automatic logic [3:0] rom_nib(input logic [3:0] addr);
      logic [3:0] v;
      case (addr)
         4'd0:    v = 4'hC;
         4'd1:    v = 4'hA;
         4'd2:    v = 4'h2;
         4'd3:    v = 4'h5;
         4'd4:    v = 4'hC;
         4'd5:    v = 4'h7;
         4'd6:    v = 4'hD;
         4'd7:    v = 4'h2;
         4'd8:    v = 4'h2;
         4'd9:    v = 4'h7;
         4'd10:   v = 4'h0;
         4'd11:   v = 4'h3;
         4'd12:   v = 4'h8;
         4'd13:   v = 4'h4;
         4'd14:   v = 4'h4;
         default: v = 4'h0;
      endcase
      return v;
   endfunction

   state_t     state_q, state_d;
   logic [3:0] ptr_q, ptr_d;
   logic [4:0] rem_q, rem_d;
   logic [3:0] gap_q, gap_d;
   logic [3:0] data_q, data_d;
   logic       load_q, load_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   logic [4:0] cnt_norm;
   logic [3:0] ptr_inc;
   logic [3:0] rd_first, rd_cur, rd_next;

   assign cnt_norm = (count == 5'd0 || count[4]) ? 5'd16 : count;
   assign ptr_inc  = ptr_q + 4'd1;

`ifdef SEQ_GEN_PROG_EN
   // Stores the difference from the ROM, so an all-zero power-up state reads back as the ROM pattern.
   logic [3:0] delta_q [16];

   always_ff @(posedge clk) begin
      if (wr_en) delta_q[wr_addr] <= wr_data ^ rom_nib(wr_addr);
   end

   assign rd_first = rom_nib(first)   ^ delta_q[first];
   assign rd_cur   = rom_nib(ptr_q)   ^ delta_q[ptr_q];
   assign rd_next  = rom_nib(ptr_inc) ^ delta_q[ptr_inc];
`else
   assign rd_first = rom_nib(first);
   assign rd_cur   = rom_nib(ptr_q);
   assign rd_next  = rom_nib(ptr_inc);
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      gap_d   = gap_q;
      data_d  = data_q;
      load_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_EMIT;
               ptr_d   = first;
               rem_d   = cnt_norm;
               data_d  = rd_first;
               load_d  = 1'b1;
               busy_d  = 1'b1;
            end
         end
         ST_EMIT: begin
            ptr_d = ptr_inc;
            rem_d = rem_q - 5'd1;
            if (GAP == 0) begin
               if (rem_q == 5'd1) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_EMIT;
                  data_d  = rd_next;
                  load_d  = 1'b1;
                  busy_d  = 1'b1;
               end
            end else begin
               state_d = ST_GAP;
               gap_d   = GAP_LAST;
               busy_d  = 1'b1;
            end
         end
         ST_GAP: begin
            if (gap_q != 4'd0) begin
               gap_d  = gap_q - 4'd1;
               busy_d = 1'b1;
            end else if (rem_q == 5'd0) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_EMIT;
               data_d  = rd_cur;
               load_d  = 1'b1;
               busy_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Abort wins over every transition above but leaves data where it was.
      if (abort && (state_q == ST_EMIT || state_q == ST_GAP)) begin
         state_d = ST_IDLE;
         ptr_d   = ptr_q;
         rem_d   = rem_q;
         gap_d   = gap_q;
         data_d  = data_q;
         load_d  = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
         gap_q   <= '0;
         data_q  <= '0;
         load_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         gap_q   <= gap_d;
         data_q  <= data_d;
         load_q  <= load_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign data = data_q;
   assign load = load_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: one GAP=1 and one GAP=0 instance, directed bursts, abort and reset.
// Pattern-write cases are compiled in when SEQ_GEN_PROG_EN is defined.
module tb_seq_gen;

   typedef struct {
      int unsigned cyc;
      logic [3:0]  d;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start1 = 1'b0, start0 = 1'b0;
   logic       abort1 = 1'b0, abort0 = 1'b0;
   logic [3:0] first = '0;
   logic [4:0] count = '0;
   logic       wr_en = 1'b0;
   logic [3:0] wr_addr = '0, wr_data = '0;
   logic [3:0] data1, data0;
   logic       load1, busy1, done1, load0, busy0, done0;

   int unsigned ecnt = 0;
   int          checks = 0;
   int          errors = 0;

   exp_t        ld1_q[$], ld0_q[$];
   int unsigned dn1_q[$], dn0_q[$];

   logic [3:0] rom [16] = '{4'hC, 4'hA, 4'h2, 4'h5, 4'hC, 4'h7, 4'hD, 4'h2,
                            4'h2, 4'h7, 4'h0, 4'h3, 4'h8, 4'h4, 4'h4, 4'h0};

   seq_gen #(.GAP(1)) u_g1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1),
      .first(first), .count(count),
`ifdef SEQ_GEN_PROG_EN
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`endif
      .data(data1), .load(load1), .busy(busy1), .done(done1)
   );

   seq_gen #(.GAP(0)) u_g0 (
      .clk(clk), .rst(rst), .start(start0), .abort(abort0),
      .first(first), .count(count),
`ifdef SEQ_GEN_PROG_EN
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`endif
      .data(data0), .load(load0), .busy(busy0), .done(done0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) ecnt <= ecnt + 1;

   // Monitor for the GAP=1 instance
   always @(negedge clk) begin
      exp_t        e;
      int unsigned c;
      if (load1 === 1'b1) begin
         checks++;
         if (ld1_q.size() == 0) begin
            errors++;
            $display("FAIL g1_load: unexpected load at cycle %0d data %h", ecnt, data1);
         end else begin
            e = ld1_q.pop_front();
            if (e.cyc != ecnt || e.d !== data1) begin
               errors++;
               $display("FAIL g1_load: got cycle %0d data %h, expected cycle %0d data %h",
                        ecnt, data1, e.cyc, e.d);
            end
         end
      end
      if (done1 === 1'b1) begin
         checks++;
         if (dn1_q.size() == 0) begin
            errors++;
            $display("FAIL g1_done: unexpected done at cycle %0d", ecnt);
         end else begin
            c = dn1_q.pop_front();
            if (c != ecnt || busy1 !== 1'b0) begin
               errors++;
               $display("FAIL g1_done: got cycle %0d busy %b, expected cycle %0d busy 0",
                        ecnt, busy1, c);
            end
         end
      end
   end

   // Monitor for the GAP=0 instance
   always @(negedge clk) begin
      exp_t        e;
      int unsigned c;
      if (load0 === 1'b1) begin
         checks++;
         if (ld0_q.size() == 0) begin
            errors++;
            $display("FAIL g0_load: unexpected load at cycle %0d data %h", ecnt, data0);
         end else begin
            e = ld0_q.pop_front();
            if (e.cyc != ecnt || e.d !== data0) begin
               errors++;
               $display("FAIL g0_load: got cycle %0d data %h, expected cycle %0d data %h",
                        ecnt, data0, e.cyc, e.d);
            end
         end
      end
      if (done0 === 1'b1) begin
         checks++;
         if (dn0_q.size() == 0) begin
            errors++;
            $display("FAIL g0_done: unexpected done at cycle %0d", ecnt);
         end else begin
            c = dn0_q.pop_front();
            if (c != ecnt || busy0 !== 1'b0) begin
               errors++;
               $display("FAIL g0_done: got cycle %0d busy %b, expected cycle %0d busy 0",
                        ecnt, busy0, c);
            end
         end
      end
   end

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push1(input int unsigned cyc, input logic [3:0] d);
      exp_t e;
      e.cyc = cyc;
      e.d   = d;
      ld1_q.push_back(e);
   endtask

   task automatic push0(input int unsigned cyc, input logic [3:0] d);
      exp_t e;
      e.cyc = cyc;
      e.d   = d;
      ld0_q.push_back(e);
   endtask

   // Called just after a negedge; s is the cycle-0 reference for relative cycle numbers
   task automatic fire(input bit g0, input logic [3:0] f, input logic [4:0] c,
                       output int unsigned s);
      first = f;
      count = c;
      if (g0) start0 = 1'b1;
      else    start1 = 1'b1;
      s = ecnt;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic wait_rel(input int unsigned s, input int unsigned rel);
      while (ecnt < s + rel) @(negedge clk);
   endtask

   initial begin
      int unsigned s;

      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      check("reset_data1", data1, 4'h0);
      check("reset_load1", {3'b0, load1}, 4'h0);
      check("reset_busy1", {3'b0, busy1}, 4'h0);
      check("reset_done1", {3'b0, done1}, 4'h0);
      check("reset_data0", data0, 4'h0);

      // Full 16-nibble burst, count=0 means 16
      s = ecnt;
      for (int i = 0; i < 16; i++) push1(s + 1 + 2 * i, rom[i]);
      dn1_q.push_back(s + 33);
      fire(1'b0, 4'd0, 5'd0, s);
      wait_rel(s, 2);
      check("gap_busy", {3'b0, busy1}, 4'h1);
      check("gap_load", {3'b0, load1}, 4'h0);
      check("gap_data_held", data1, 4'hC);
      wait_rel(s, 36);

      // Address wrap 15 -> 0, data held after burst
      s = ecnt;
      push1(s + 1, 4'h4);
      push1(s + 3, 4'h0);
      push1(s + 5, 4'hC);
      dn1_q.push_back(s + 7);
      fire(1'b0, 4'd14, 5'd3, s);
      wait_rel(s, 9);
      check("held_after_burst", data1, 4'hC);
      check("idle_busy", {3'b0, busy1}, 4'h0);

      // GAP=0 back-to-back loads
      s = ecnt;
      push0(s + 1, 4'h2);
      push0(s + 2, 4'h7);
      push0(s + 3, 4'h0);
      push0(s + 4, 4'h3);
      dn0_q.push_back(s + 5);
      fire(1'b1, 4'd8, 5'd4, s);
      wait_rel(s, 8);

      // Second start mid-burst must be ignored
      s = ecnt;
      for (int i = 0; i < 8; i++) push1(s + 1 + 2 * i, rom[i]);
      dn1_q.push_back(s + 17);
      fire(1'b0, 4'd0, 5'd8, s);
      wait_rel(s, 4);
      first  = 4'd5;
      count  = 5'd2;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      wait_rel(s, 24);

      // Abort during cycle 5 of a 16-nibble burst
      s = ecnt;
      push1(s + 1, 4'hC);
      push1(s + 3, 4'hA);
      push1(s + 5, 4'h2);
      fire(1'b0, 4'd0, 5'd16, s);
      wait_rel(s, 5);
      abort1 = 1'b1;
      @(negedge clk);
      abort1 = 1'b0;
      check("abort_load", {3'b0, load1}, 4'h0);
      check("abort_busy", {3'b0, busy1}, 4'h0);
      check("abort_data_held", data1, 4'h2);
      wait_rel(s, 40);

      // Asynchronous reset mid-burst, then start on the first edge after release
      s = ecnt;
      push1(s + 1, 4'h5);
      fire(1'b0, 4'd3, 5'd0, s);
      wait_rel(s, 2);
      #2 rst = 1'b0;
      #1;
      check("rst_data1", data1, 4'h0);
      check("rst_load1", {3'b0, load1}, 4'h0);
      check("rst_busy1", {3'b0, busy1}, 4'h0);
      check("rst_done1", {3'b0, done1}, 4'h0);
      check("rst_data0", data0, 4'h0);
      @(negedge clk);
      first  = 4'd6;
      count  = 5'd1;
      start1 = 1'b1;
      s = ecnt;
      push1(s + 1, 4'hD);
      dn1_q.push_back(s + 3);
      #2 rst = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      wait_rel(s, 6);

`ifdef SEQ_GEN_PROG_EN
      // Pattern write, then emit it
      wr_en   = 1'b1;
      wr_addr = 4'd0;
      wr_data = 4'hF;
      @(negedge clk);
      wr_en = 1'b0;
      s = ecnt;
      push1(s + 1, 4'hF);
      dn1_q.push_back(s + 3);
      fire(1'b0, 4'd0, 5'd1, s);
      wait_rel(s, 5);

      // Write on the start edge: old value is emitted, new value on the next burst
      wr_en   = 1'b1;
      wr_addr = 4'd1;
      wr_data = 4'h9;
      s = ecnt;
      push1(s + 1, 4'hA);
      dn1_q.push_back(s + 3);
      fire(1'b0, 4'd1, 5'd1, s);
      wr_en = 1'b0;
      wait_rel(s, 5);
      s = ecnt;
      push1(s + 1, 4'h9);
      dn1_q.push_back(s + 3);
      fire(1'b0, 4'd1, 5'd1, s);
      wait_rel(s, 5);

      // Reset leaves the pattern memory alone
      #2 rst = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      s = ecnt;
      push1(s + 1, 4'hF);
      dn1_q.push_back(s + 3);
      fire(1'b0, 4'd0, 5'd1, s);
      wait_rel(s, 5);
`endif

      repeat (10) @(negedge clk);
      checks++;
      if (ld1_q.size() + ld0_q.size() + dn1_q.size() + dn0_q.size() != 0) begin
         errors++;
         $display("FAIL pending_expect: got %0d outstanding entries expected 0",
                  ld1_q.size() + ld0_q.size() + dn1_q.size() + dn0_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
